// File: rtl/cmp_stream.sv
// cmp_stream: pipelined signed/unsigned magnitude comparator with a
// valid/ready handshake, a single result register, saturating outcome
// counters and min/max tracking of operand a.
module cmp_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [WIDTH-1:0] a_max,
    output logic [WIDTH-1:0] a_min,
    output logic             stats_vld
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};

    // x < y; in signed mode flipping both sign bits maps two's complement
    // onto offset binary so a plain unsigned compare gives the right order.
    function automatic logic less_than(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic             sgn);
        logic [WIDTH-1:0] xb;
        logic [WIDTH-1:0] yb;
        xb = x;
        yb = y;
        if (sgn) begin
            xb[WIDTH-1] = ~x[WIDTH-1];
            yb[WIDTH-1] = ~y[WIDTH-1];
        end else begin
            xb = x;
            yb = y;
        end
        return (xb < yb);
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == CNT_MAX) begin
            r = c;
        end else begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

    logic             out_valid_r;
    logic             agtb_r, aeqb_r, altb_r;
    logic [CNT_W-1:0] cnt_gt_r, cnt_eq_r, cnt_lt_r;
    logic [WIDTH-1:0] a_max_r, a_min_r;
    logic             stats_vld_r;

    logic             accept_s;
    logic             gt_s, lt_s, eq_s;
    logic             out_valid_s;
    logic             agtb_s, aeqb_s, altb_s;
    logic [CNT_W-1:0] cnt_gt_s, cnt_eq_s, cnt_lt_s;
    logic [WIDTH-1:0] a_max_s, a_min_s;
    logic             stats_vld_s;

    // Ready depends only on the result register state and the consumer.
    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Three-way compare of the presented operands in the requested mode.
    always_comb begin
        lt_s = less_than(a, b, is_signed);
        gt_s = less_than(b, a, is_signed);
        eq_s = !lt_s && !gt_s;
    end

    // Result register next state: load on accept, drain on pop, else hold.
    always_comb begin
        out_valid_s = out_valid_r;
        agtb_s      = agtb_r;
        aeqb_s      = aeqb_r;
        altb_s      = altb_r;
        if (accept_s) begin
            out_valid_s = 1'b1;
            agtb_s      = gt_s;
            aeqb_s      = eq_s;
            altb_s      = lt_s;
        end else if (out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // Statistics next state: clear first, then fold in an accepted sample so
    // a simultaneous clear+accept lands in the fresh statistics.
    always_comb begin
        cnt_gt_s    = cnt_gt_r;
        cnt_eq_s    = cnt_eq_r;
        cnt_lt_s    = cnt_lt_r;
        a_max_s     = a_max_r;
        a_min_s     = a_min_r;
        stats_vld_s = stats_vld_r;
        if (clear) begin
            cnt_gt_s    = CNT_ZERO;
            cnt_eq_s    = CNT_ZERO;
            cnt_lt_s    = CNT_ZERO;
            a_max_s     = VAL_ZERO;
            a_min_s     = VAL_ZERO;
            stats_vld_s = 1'b0;
        end else begin
            stats_vld_s = stats_vld_r;
        end
        if (accept_s) begin
            if (gt_s) begin
                cnt_gt_s = sat_inc(cnt_gt_s);
            end else if (lt_s) begin
                cnt_lt_s = sat_inc(cnt_lt_s);
            end else begin
                cnt_eq_s = sat_inc(cnt_eq_s);
            end
            if (!stats_vld_s) begin
                a_max_s = a;
                a_min_s = a;
            end else begin
                if (less_than(a_max_s, a, is_signed)) begin
                    a_max_s = a;
                end else begin
                    a_max_s = a_max_s;
                end
                if (less_than(a, a_min_s, is_signed)) begin
                    a_min_s = a;
                end else begin
                    a_min_s = a_min_s;
                end
            end
            stats_vld_s = 1'b1;
        end else begin
            stats_vld_s = stats_vld_s;
        end
    end

    // State registers; reset shows an "equal" result with nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            agtb_r      <= 1'b0;
            aeqb_r      <= 1'b1;
            altb_r      <= 1'b0;
            cnt_gt_r    <= CNT_ZERO;
            cnt_eq_r    <= CNT_ZERO;
            cnt_lt_r    <= CNT_ZERO;
            a_max_r     <= VAL_ZERO;
            a_min_r     <= VAL_ZERO;
            stats_vld_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_s;
            agtb_r      <= agtb_s;
            aeqb_r      <= aeqb_s;
            altb_r      <= altb_s;
            cnt_gt_r    <= cnt_gt_s;
            cnt_eq_r    <= cnt_eq_s;
            cnt_lt_r    <= cnt_lt_s;
            a_max_r     <= a_max_s;
            a_min_r     <= a_min_s;
            stats_vld_r <= stats_vld_s;
        end
    end

    assign out_valid = out_valid_r;
    assign agtb      = agtb_r;
    assign aeqb      = aeqb_r;
    assign altb      = altb_r;
    assign cnt_gt    = cnt_gt_r;
    assign cnt_eq    = cnt_eq_r;
    assign cnt_lt    = cnt_lt_r;
    assign a_max     = a_max_r;
    assign a_min     = a_min_r;
    assign stats_vld = stats_vld_r;

endmodule
